// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and constants for the fetch stage
package cpu_pkg;

    localparam int CPU_INST_W = 16;
    localparam int CPU_ADDR_W = 7;
    localparam int CPU_OFF_W  = 6;
    localparam int CPU_DEPTH  = 4;

    localparam logic [CPU_INST_W-1:0] CPU_NOP = '0;

endpackage

// File: rtl/if_prefetch_if.sv
// rtl/if_prefetch_if.sv - ROM, redirect and decode-side signals of the prefetcher
interface if_prefetch_if #(
    parameter int INST_W = 16,
    parameter int ADDR_W = 7,
    parameter int OFF_W  = 6,
    parameter int DEPTH  = 4
);

    logic [ADDR_W-1:0]        rom_addr_o;
    logic [INST_W-1:0]        rom_inst_i;
    logic                     jump_en_i;
    logic [ADDR_W-1:0]        jump_base_i;
    logic [OFF_W-1:0]         jump_offset_i;
    logic [INST_W-1:0]        inst_o;
    logic [ADDR_W-1:0]        inst_addr_o;
    logic                     inst_valid_o;
    logic                     inst_ready_i;
    logic [$clog2(DEPTH):0]   level_o;

    modport master (
        output rom_addr_o,
        input  rom_inst_i,
        input  jump_en_i,
        input  jump_base_i,
        input  jump_offset_i,
        output inst_o,
        output inst_addr_o,
        output inst_valid_o,
        input  inst_ready_i,
        output level_o
    );

    modport slave (
        input  rom_addr_o,
        output rom_inst_i,
        output jump_en_i,
        output jump_base_i,
        output jump_offset_i,
        input  inst_o,
        input  inst_addr_o,
        input  inst_valid_o,
        output inst_ready_i,
        input  level_o
    );

endinterface

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - prefetch entry storage with wrapping pointers and occupancy count
module if_fifo #(
    parameter int W     = 23,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; full vs. empty is told apart by level alone.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign valid = (level != '0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction prefetch stage: PC, branch redirect and prefetch buffer
module if_prefetch
    import cpu_pkg::*;
#(
    parameter int INST_W = CPU_INST_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int OFF_W  = CPU_OFF_W,
    parameter int DEPTH  = CPU_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    if_prefetch_if.master   bus
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = INST_W + ADDR_W;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] offset_ext;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic [EW-1:0]     head;
    logic [LW-1:0]     level;

    assign offset_ext = ADDR_W'($signed(bus.jump_offset_i));
    assign target     = bus.jump_base_i + offset_ext;

    // A redirect wins over everything: no push, no pop, buffer flushed.
    assign pop  = head_valid && bus.inst_ready_i && !bus.jump_en_i;
    assign push = !bus.jump_en_i && ((level < LW'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (bus.jump_en_i) begin
            pc <= target;
        end else if (push) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    if_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.jump_en_i),
        .din   ({pc, bus.rom_inst_i}),
        .dout  (head),
        .valid (head_valid),
        .level (level)
    );

    assign bus.rom_addr_o   = pc;
    assign bus.inst_valid_o = head_valid;
    assign bus.inst_o       = head_valid ? head[INST_W-1:0] : INST_W'(CPU_NOP);
    assign bus.inst_addr_o  = head_valid ? head[EW-1:INST_W] : '0;
    assign bus.level_o      = level;

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - directed self-checking bench for if_prefetch
module tb_if_prefetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    if_prefetch_if #(.INST_W(16), .ADDR_W(7), .OFF_W(6), .DEPTH(4)) bus ();

    if_prefetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROM image: ROM[a] = 0x1000 + a
    assign bus.rom_inst_i = 16'h1000 + {9'd0, bus.rom_addr_o};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.jump_en_i     = 1'b0;
        bus.jump_base_i   = '0;
        bus.jump_offset_i = '0;
        bus.inst_ready_i  = 1'b0;

        // reset state
        step();
        step();
        check("rst_level", bus.level_o, 0);
        check("rst_valid", bus.inst_valid_o, 0);
        check("rst_inst", bus.inst_o, 0);
        check("rst_inst_addr", bus.inst_addr_o, 0);
        check("rst_rom_addr", bus.rom_addr_o, 0);

        // streaming with decode always ready
        rst = 1'b0;
        bus.inst_ready_i = 1'b1;
        check("first_rom_addr", bus.rom_addr_o, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("stream_valid", bus.inst_valid_o, 1);
            check("stream_addr", bus.inst_addr_o, i);
            check("stream_inst", bus.inst_o, 32'h1000 + i);
            check("stream_rom_addr", bus.rom_addr_o, i + 1);
            check("stream_level", bus.level_o, 1);
        end

        // back-pressure: fill to DEPTH and hold
        rst = 1'b1;
        bus.inst_ready_i = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("fill_level", bus.level_o, (k < 4) ? k : 4);
            check("fill_rom_addr", bus.rom_addr_o, (k < 4) ? k : 4);
            check("fill_head_addr", bus.inst_addr_o, 0);
            check("fill_head_inst", bus.inst_o, 32'h1000);
        end
        check("fill_valid", bus.inst_valid_o, 1);

        // full with a single pop: push and pop together
        bus.inst_ready_i = 1'b1;
        step();
        bus.inst_ready_i = 1'b0;
        check("full_pp_level", bus.level_o, 4);
        check("full_pp_rom_addr", bus.rom_addr_o, 5);
        check("full_pp_head_addr", bus.inst_addr_o, 1);
        check("full_pp_head_inst", bus.inst_o, 32'h1001);
        step();
        check("full_hold_level", bus.level_o, 4);
        check("full_hold_rom_addr", bus.rom_addr_o, 5);
        check("full_hold_head_addr", bus.inst_addr_o, 1);

        // redirect with negative offset
        bus.jump_en_i     = 1'b1;
        bus.jump_base_i   = 7'h10;
        bus.jump_offset_i = 6'h3D;
        step();
        bus.jump_en_i = 1'b0;
        check("jmp_rom_addr", bus.rom_addr_o, 7'h0D);
        check("jmp_level", bus.level_o, 0);
        check("jmp_valid", bus.inst_valid_o, 0);
        check("jmp_inst_nop", bus.inst_o, 0);
        check("jmp_inst_addr", bus.inst_addr_o, 0);
        step();
        check("jmp_tgt_valid", bus.inst_valid_o, 1);
        check("jmp_tgt_addr", bus.inst_addr_o, 7'h0D);
        check("jmp_tgt_inst", bus.inst_o, 32'h100D);
        check("jmp_tgt_rom_addr", bus.rom_addr_o, 7'h0E);

        // target wrap and most-negative offset
        bus.jump_en_i     = 1'b1;
        bus.jump_base_i   = 7'h7F;
        bus.jump_offset_i = 6'h02;
        step();
        check("jmp_wrap_rom_addr", bus.rom_addr_o, 7'h01);
        bus.jump_base_i   = 7'h05;
        bus.jump_offset_i = 6'h20;
        step();
        check("jmp_minoff_rom_addr", bus.rom_addr_o, 7'h65);
        bus.jump_base_i   = 7'h7C;
        bus.jump_offset_i = 6'h03;
        step();
        bus.jump_en_i    = 1'b0;
        bus.inst_ready_i = 1'b1;
        check("pc_7f_rom_addr", bus.rom_addr_o, 7'h7F);
        step();
        check("pc_wrap_rom_addr", bus.rom_addr_o, 7'h00);
        check("pc_wrap_head_addr", bus.inst_addr_o, 7'h7F);
        check("pc_wrap_head_inst", bus.inst_o, 32'h107F);
        step();
        check("pc_after_rom_addr", bus.rom_addr_o, 7'h01);
        check("pc_after_head_addr", bus.inst_addr_o, 7'h00);
        check("pc_after_head_inst", bus.inst_o, 32'h1000);

        // reset overrides a same-cycle redirect with three entries held
        bus.inst_ready_i  = 1'b0;
        bus.jump_en_i     = 1'b1;
        bus.jump_base_i   = 7'h20;
        bus.jump_offset_i = 6'h00;
        step();
        bus.jump_en_i = 1'b0;
        check("pre_rst_level0", bus.level_o, 0);
        step();
        step();
        step();
        check("pre_rst_level3", bus.level_o, 3);
        check("pre_rst_rom_addr", bus.rom_addr_o, 7'h23);
        rst               = 1'b1;
        bus.jump_en_i     = 1'b1;
        bus.jump_base_i   = 7'h10;
        bus.jump_offset_i = 6'h05;
        step();
        check("rstjmp_rom_addr", bus.rom_addr_o, 0);
        check("rstjmp_level", bus.level_o, 0);
        check("rstjmp_valid", bus.inst_valid_o, 0);
        rst           = 1'b0;
        bus.jump_en_i = 1'b0;
        step();
        check("post_rst_valid", bus.inst_valid_o, 1);
        check("post_rst_head_addr", bus.inst_addr_o, 0);
        check("post_rst_level", bus.level_o, 1);
        check("post_rst_rom_addr", bus.rom_addr_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter: INST_W, 16, instruction width in bits.
REQ-002 Parameter: ADDR_W, 7, instruction address width; the PC wraps modulo 2^ADDR_W.
REQ-003 Parameter: OFF_W, 6, width of the signed branch offset.
REQ-004 Parameter: DEPTH, 4, prefetch buffer entries; power of two, minimum 2.
REQ-005 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port: rst  in  1  reset, synchronous and active-high.
REQ-007 Port: rom_addr_o  out  ADDR_W  fetch address to instruction ROM; this is the current PC.
REQ-008 Port: rom_inst_i  in  INST_W  ROM data for rom_addr_o, combinational in the same cycle.
REQ-009 Port: jump_en_i  in  1  branch redirect request from EX.
REQ-010 Port: jump_base_i  in  ADDR_W  address of the branching instruction.
REQ-011 Port: jump_offset_i  in  OFF_W  signed two's-complement offset.
REQ-012 Port: inst_o  out  INST_W  instruction at the buffer head.
REQ-013 Port: inst_addr_o  out  ADDR_W  address of inst_o.
REQ-014 Port: inst_valid_o  out  1  head entry valid.
REQ-015 Port: inst_ready_i  in  1  decode accepts the head this cycle.
REQ-016 Port: level_o  out  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Push condition: no jump_en_i, and either level_o<DEPTH or a pop occurs in the same cycle; a push stores {rom_addr_o, rom_inst_i} at the tail and increments the PC by 1 with wrap.
REQ-018 Pop condition: inst_valid_o=1, inst_ready_i=1, and no jump_en_i; a pop removes the head entry.
REQ-019 If the buffer is full and no pop occurs, there is no push and the PC holds.
REQ-020 Simultaneous push and pop: level_o is unchanged, and a full buffer stays full with no lost entry.
REQ-021 Redirect target: PC <= (jump_base_i + sign-extended jump_offset_i) mod 2^ADDR_W.
REQ-022 A redirect flushes all entries (level_o <= 0) and suppresses both push and pop that cycle.
REQ-023 A redirect takes priority over push, pop and full.
REQ-024 Empty buffer: inst_valid_o=0, inst_o=0 (NOP), inst_addr_o=0.
REQ-025 Head outputs are taken directly from registered storage; there is no combinational path from rom_inst_i to inst_o.
REQ-026 Latency: an address on rom_addr_o in cycle n appears on inst_o in cycle n+1 at the earliest.
REQ-027 Redirect asserted in cycle k: rom_addr_o=target and inst_valid_o=0 in cycle k+1; the target instruction is valid in cycle k+2.
REQ-028 Pointers wrap modulo DEPTH; the full/empty distinction is made using level_o.
REQ-029 Head entry, head outputs and inst_valid_o hold stable while inst_valid_o=1 and inst_ready_i=0.

Reset
REQ-030 While rst=1 at a clock edge: PC=0, level_o=0, inst_valid_o=0, inst_o=0, inst_addr_o=0, and both pointers=0.
REQ-031 Reset asserted mid-operation discards all entries and overrides a same-cycle jump_en_i.
REQ-032 In the first cycle after reset deasserts: rom_addr_o=0 and a push occurs.

Structure
REQ-033 INST_W/ADDR_W defaults and the NOP constant (all zeros) live in the shared package cpu_pkg.
REQ-034 Storage and pointers live in one sub-module, if_fifo (parameters INST_W+ADDR_W, DEPTH; ports push, pop, flush, level); PC and redirect logic stay in if_prefetch.

Verification
REQ-035 Reset release, inst_ready_i=1, ROM[a]=0x1000+a -> inst_addr_o=0,1,2,... on consecutive cycles from cycle 1, inst_o=0x1000,0x1001,...
REQ-036 inst_ready_i=0 for 10 cycles, DEPTH=4 -> level_o saturates at 4, rom_addr_o holds at 4, head stays addr 0.
REQ-037 Buffer full, inst_ready_i=1 for one cycle -> one push and one pop, level_o stays 4, rom_addr_o advances by 1.
REQ-038 jump_en_i with base=0x10 and offset=-3 (6'h3D) -> next cycle rom_addr_o=0x0D, level_o=0, valid=0; following cycle inst_addr_o=0x0D.
REQ-039 base=0x7F, offset=+2 -> target 0x01 (wrap); PC=0x7F free-running -> next address 0x00.
REQ-040 rst and jump_en_i asserted together with level_o=3 -> next cycle rom_addr_o=0, level_o=0, inst_valid_o=0.
